// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N decoder with active-low enable and active-low one-hot outputs.
// Besides plain decoding it can hold one line for a dwell (PULSE) or walk all lines (SCAN).
module decoder_seq_n #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         in,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         index,
    output logic [(1<<N)-1:0]    out
);

    localparam int LINES = 1 << N;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state_q;
    logic [N-1:0]         line_q;
    logic [N-1:0]         left_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic [LINES-1:0]     out_q;
    logic                 busy_q;
    logic                 done_q;
    logic [N-1:0]         index_q;

    logic [DWELL_W-1:0]   dwell_d;
    logic [N-1:0]         line_d;
    logic                 accept;
    logic                 last_dwell;
    logic                 last_line;

    function automatic logic [LINES-1:0] dec_n(input logic [N-1:0] sel);
        logic [LINES-1:0] v;
        v      = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    always_comb begin
        dwell_d    = (dwell == '0) ? DWELL_W'(1) : dwell;
        line_d     = line_q + N'(1);
        accept     = (state_q == IDLE) && start &&
                     ((mode == MODE_PULSE) || (mode == MODE_SCAN));
        last_dwell = (cnt_q == DWELL_W'(1));
        // left_q counts lines still to visit after the current one
        last_line  = (left_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            left_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            out_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
        end else if (enable) begin
            // abort: index keeps its last value, no done pulse
            state_q <= IDLE;
            out_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= ACTIVE;
                        line_q  <= in;
                        left_q  <= (mode == MODE_SCAN) ? N'(LINES - 1) : '0;
                        dwell_q <= dwell_d;
                        cnt_q   <= dwell_d;
                        out_q   <= dec_n(in);
                        busy_q  <= 1'b1;
                        index_q <= in;
                    end else if (mode == MODE_DIRECT) begin
                        out_q   <= dec_n(in);
                        busy_q  <= 1'b0;
                        index_q <= in;
                    end else begin
                        out_q   <= '1;
                        busy_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!last_dwell) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (last_line) begin
                        state_q <= IDLE;
                        out_q   <= '1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        line_q  <= line_d;
                        left_q  <= left_q - N'(1);
                        cnt_q   <= dwell_q;
                        out_q   <= dec_n(line_d);
                        index_q <= line_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign index = index_q;

endmodule

// File: tb/tb_decoder_seq_n.sv
// Self-checking bench for decoder_seq_n (N=2): directed scenarios plus random traffic,
// compared each cycle against an elapsed-time reference model.
module tb_decoder_seq_n;

    localparam int N       = 2;
    localparam int L       = 1 << N;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [1:0]         md;
    logic [N-1:0]       sel;
    logic [DWELL_W-1:0] dw;
    logic               st;
    logic               busy;
    logic               done;
    logic [N-1:0]       idx;
    logic [L-1:0]       out_w;

    int passed = 0;
    int checks = 0;

    // reference model state
    int           cyc = 0;
    bit           m_act = 0;
    int           m_k, m_s, m_D, m_total;
    logic [L-1:0] m_out = '1;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_idx = '0;

    decoder_seq_n #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .reset(rst), .enable(en), .mode(md), .in(sel), .dwell(dw),
        .start(st), .busy(busy), .done(done), .index(idx), .out(out_w)
    );

    always #5 clk = ~clk;

    // Operation is described by its acceptance cycle: line = s + elapsed/D (mod L).
    task automatic model_step();
        int n;
        int ln;
        logic [L-1:0] one;
        one = 1;
        cyc++;
        if (rst) begin
            m_act = 0; m_out = '1; m_busy = 0; m_done = 0; m_idx = '0;
        end else if (en) begin
            m_act = 0; m_out = '1; m_busy = 0; m_done = 0;
        end else begin
            if (!m_act && st && (md == 2'd1 || md == 2'd2)) begin
                m_act   = 1;
                m_k     = cyc;
                m_s     = int'(sel);
                m_D     = (dw == 0) ? 1 : int'(dw);
                m_total = m_D * ((md == 2'd2) ? L : 1);
            end
            if (m_act) begin
                n = cyc - m_k;
                if (n < m_total) begin
                    ln     = (m_s + n / m_D) % L;
                    m_out  = ~(one << ln);
                    m_busy = 1; m_done = 0;
                    m_idx  = ln[N-1:0];
                end else begin
                    m_act = 0; m_out = '1; m_busy = 0; m_done = 1;
                end
            end else if (md == 2'd0) begin
                m_out = ~(one << sel);
                m_idx = sel; m_busy = 0; m_done = 0;
            end else begin
                m_out = '1; m_busy = 0; m_done = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; md = 2'd1; st = 1; sel = 2'd2; dw = 8'd3;
        repeat (2) begin
            tick();
            checks++;
            if (out_w !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'd0)
                $display("FAIL reset out=%b busy=%b done=%b index=%0d want 1111/0/0/0", out_w, busy, done, idx);
            else passed++;
        end
        rst = 0; en = 1; md = 2'd0; st = 0;
        tick();
        checks++;
        if (out_w !== 4'b1111 || busy !== 1'b0 || out_w !== m_out)
            $display("FAIL reset_release out=%b busy=%b want 1111/0", out_w, busy);
        else passed++;
    endtask

    task automatic test_direct();
        logic [L-1:0] exp;
        en = 0; md = 2'd0; st = 0;
        for (int i = 0; i < L; i++) begin
            sel = N'(i);
            tick();
            exp = '1; exp[i] = 1'b0;
            checks++;
            if (out_w !== exp || idx !== N'(i) || busy !== 1'b0 || out_w !== m_out)
                $display("FAIL direct in=%0d out=%b want %b index=%0d", i, out_w, exp, idx);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            sel = N'($urandom_range(0, L - 1));
            tick();
            checks++;
            if (out_w !== m_out || busy !== m_busy || done !== m_done || idx !== m_idx)
                $display("FAIL direct_rand out=%b/%b busy=%b/%b done=%b/%b index=%0d/%0d", out_w, m_out, busy, m_busy, done, m_done, idx, m_idx);
            else passed++;
        end
        en = 1;
        tick();
        checks++;
        if (out_w !== 4'b1111 || busy !== 1'b0)
            $display("FAIL direct_disable out=%b want 1111", out_w);
        else passed++;
    endtask

    task automatic test_pulse();
        int d;
        for (int r = 0; r < 2; r++) begin
            d  = (r == 0) ? 3 : 1;
            en = 0; md = 2'd1; sel = 2'd2; dw = (r == 0) ? 8'd3 : 8'd0; st = 1;
            tick();
            st = 0;
            for (int j = 1; j <= d + 1; j++) begin
                if (j > 1) begin
                    sel = N'($urandom_range(0, L - 1));
                    dw  = DWELL_W'($urandom_range(0, 9));
                    md  = 2'($urandom_range(0, 3));
                    tick();
                end
                checks++;
                if (j <= d) begin
                    if (out_w !== 4'b1011 || busy !== 1'b1 || done !== 1'b0 || idx !== 2'd2)
                        $display("FAIL pulse r=%0d j=%0d out=%b busy=%b done=%b want 1011/1/0", r, j, out_w, busy, done);
                    else passed++;
                end else begin
                    if (out_w !== 4'b1111 || busy !== 1'b0 || done !== 1'b1)
                        $display("FAIL pulse_done r=%0d out=%b busy=%b done=%b want 1111/0/1", r, out_w, busy, done);
                    else passed++;
                end
                checks++;
                if (out_w !== m_out || busy !== m_busy || done !== m_done || idx !== m_idx)
                    $display("FAIL pulse_model out=%b/%b busy=%b/%b done=%b/%b index=%0d/%0d", out_w, m_out, busy, m_busy, done, m_done, idx, m_idx);
                else passed++;
            end
        end
    endtask

    task automatic test_scan();
        int seq [8] = '{3, 3, 0, 0, 1, 1, 2, 2};
        logic [L-1:0] exp;
        en = 0; md = 2'd2; sel = 2'd3; dw = 8'd2; st = 1;
        tick();
        st = 0;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin
                sel = N'($urandom_range(0, L - 1));
                dw  = DWELL_W'($urandom_range(0, 9));
                md  = (j == 3) ? 2'd1 : 2'($urandom_range(0, 3));
                st  = (j == 3);
                tick();
                st  = 0;
            end
            checks++;
            if (j < 8) begin
                exp = '1; exp[seq[j]] = 1'b0;
                if (out_w !== exp || busy !== 1'b1 || done !== 1'b0 || idx !== N'(seq[j]))
                    $display("FAIL scan j=%0d out=%b want %b busy=%b index=%0d", j, out_w, exp, busy, idx);
                else passed++;
            end else begin
                if (out_w !== 4'b1111 || busy !== 1'b0 || done !== 1'b1)
                    $display("FAIL scan_done out=%b busy=%b done=%b want 1111/0/1", out_w, busy, done);
                else passed++;
            end
        end
        md = 2'd3;
        tick();
        checks++;
        if (out_w !== 4'b1111 || done !== 1'b0 || done !== m_done || busy !== m_busy)
            $display("FAIL scan_after out=%b done=%b want 1111/0", out_w, done);
        else passed++;
    endtask

    task automatic test_abort();
        en = 0; md = 2'd2; sel = N'($urandom_range(0, L - 1)); dw = 8'd5; st = 1;
        tick();
        st = 0;
        repeat (3) begin
            tick();
            checks++;
            if (out_w !== m_out || busy !== 1'b1 || idx !== m_idx)
                $display("FAIL abort_run out=%b/%b busy=%b index=%0d/%0d", out_w, m_out, busy, idx, m_idx);
            else passed++;
        end
        en = 1;
        repeat (2) begin
            tick();
            checks++;
            if (out_w !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || idx !== m_idx)
                $display("FAIL abort out=%b busy=%b done=%b want 1111/0/0 index=%0d/%0d", out_w, busy, done, idx, m_idx);
            else passed++;
        end
        en = 0; md = 2'd1; sel = 2'd1; dw = 8'd6; st = 1;
        tick();
        st = 0;
        tick();
        checks++;
        if (out_w !== 4'b1101 || busy !== 1'b1)
            $display("FAIL reset_mid_pre out=%b busy=%b want 1101/1", out_w, busy);
        else passed++;
        rst = 1;
        tick();
        checks++;
        if (out_w !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'd0)
            $display("FAIL reset_mid out=%b busy=%b done=%b index=%0d want 1111/0/0/0", out_w, busy, done, idx);
        else passed++;
        rst = 0;
        tick();
        checks++;
        if (out_w !== m_out || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_after out=%b/%b busy=%b done=%b", out_w, m_out, busy, done);
        else passed++;
    endtask

    task automatic test_back_to_back();
        en = 0; md = 2'd1; sel = 2'd1; dw = 8'd1; st = 1;
        tick();
        st = 0;
        checks++;
        if (out_w !== 4'b1101 || busy !== 1'b1)
            $display("FAIL b2b_first out=%b busy=%b want 1101/1", out_w, busy);
        else passed++;
        tick();
        checks++;
        if (out_w !== 4'b1111 || done !== 1'b1)
            $display("FAIL b2b_done out=%b done=%b want 1111/1", out_w, done);
        else passed++;
        md = 2'd1; sel = 2'd3; dw = 8'd2; st = 1;
        tick();
        st = 0;
        checks++;
        if (out_w !== 4'b0111 || busy !== 1'b1 || done !== 1'b0 || idx !== 2'd3)
            $display("FAIL b2b_second out=%b busy=%b done=%b want 0111/1/0", out_w, busy, done);
        else passed++;
        repeat (2) tick();
        checks++;
        if (out_w !== m_out || done !== 1'b1 || busy !== m_busy)
            $display("FAIL b2b_second_done out=%b/%b done=%b want 1", out_w, m_out, done);
        else passed++;
        md = 2'd3; sel = 2'd0; st = 1;
        repeat (2) begin
            tick();
            checks++;
            if (out_w !== 4'b1111 || busy !== 1'b0 || done !== m_done)
                $display("FAIL mode11 out=%b busy=%b done=%b want 1111/0/%b", out_w, busy, done, m_done);
            else passed++;
        end
        st = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 15) == 0);
            md  = 2'($urandom_range(0, 3));
            sel = N'($urandom_range(0, L - 1));
            dw  = DWELL_W'($urandom_range(0, 3));
            st  = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (out_w !== m_out || busy !== m_busy || done !== m_done || idx !== m_idx)
                $display("FAIL random cyc=%0d out=%b/%b busy=%b/%b done=%b/%b index=%0d/%0d", cyc, out_w, m_out, busy, m_busy, done, m_done, idx, m_idx);
            else passed++;
        end
        rst = 0; en = 1; st = 0;
    endtask

    initial begin
        rst = 1; en = 1; md = 2'd0; sel = '0; dw = '0; st = 0;
        test_reset();
        test_direct();
        test_pulse();
        test_scan();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
- Parametrised, registered N-to-2^N decoder with active-low enable and active-low one-hot outputs.
- Adds timed operation to plain decoding:
  - DIRECT: registered decode.
  - PULSE: assert one line for a programmable dwell.
  - SCAN: walk every line in turn, each for a programmable dwell.
- Used as a chip-select / strobe generator between control logic and banked peripherals.

Parameters:
- N, default 2: select (address) width; the block drives 2^N output lines.
- DWELL_W, default 8: width of the dwell counter and of the dwell input.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: active-low enable. 1 forces all outputs inactive and aborts any operation.
- mode, input, 2: 00 DIRECT, 01 PULSE, 10 SCAN, 11 reserved.
- in, input, N: line select (DIRECT/PULSE) or start line (SCAN).
- dwell, input, DWELL_W: cycles each line is held low in PULSE/SCAN. 0 is treated as 1.
- start, input, 1: single-cycle request to begin a PULSE/SCAN operation.
- busy, output, 1: high while a PULSE/SCAN operation is driving a line.
- done, output, 1: one-cycle pulse when an operation completes normally.
- index, output, N: number of the line currently low, or last decoded line.
- out, output, 2^N: active-low one-hot outputs. At most one bit is 0 in any cycle.

Behaviour:
- Reset (reset=1 at a clock edge):
  - out = all ones, busy=0, done=0, index=0, state=IDLE, counters cleared.
  - Reset dominates enable, start and mode, including mid-operation.
- Registers are updated only on the rising edge of clk.
- States: IDLE, ACTIVE.
  - done is a registered one-cycle flag set on the ACTIVE->IDLE transition.
- enable=1 (inactive):
  - Next cycle: out = all ones, busy=0, state=IDLE.
  - Any operation is aborted; done is NOT pulsed; index holds its value.
  - start is ignored.
- IDLE, enable=0:
  - mode=00 (DIRECT): out = ~(1<<in) and index = in, registered, latency 1 cycle. busy=0.
  - mode=01/10 with start=0: out = all ones.
  - mode=11: out = all ones; start is ignored.
- Start acceptance:
  - Conditions: state IDLE, enable=0, start=1, mode=01 or 10.
  - Captured at that edge: mode, in, and D = max(dwell,1).
  - Changes to mode, in or dwell afterwards do not affect the running operation.
- PULSE, start accepted at edge k:
  - Cycles k+1 .. k+D: out[in]=0, busy=1, index=in.
  - Cycle k+D+1: out = all ones, busy=0, done=1, state=IDLE.
- SCAN, start accepted at edge k, with start line s:
  - Lines s, s+1, ... (mod 2^N, wrap from 2^N-1 to 0) are each held low for D cycles.
  - All 2^N lines are visited exactly once, with no gap cycle between lines.
  - busy=1 for 2^N*D cycles.
  - The cycle after the last dwell: out = all ones, done=1.
- start while ACTIVE is ignored (no queueing).
- start in the done cycle is accepted (state is IDLE): the new operation drives a line the next cycle, and done falls.
- Dwell counter: DWELL_W bits, counts down from D to 1. The line advances or the operation ends when it reaches 1. No overflow is possible.
- The scan line counter is N bits and wraps naturally.

Test Plan:
- N=2, reset held 2 cycles -> out=4'b1111, busy=0, done=0, index=0. Then release with enable=1, mode=00 -> out stays 4'b1111.
- DIRECT, enable=0, in=0,1,2,3 applied one per cycle -> out=1110,1101,1011,0111, each one cycle after its in value; index tracks in. Then enable=1 -> out=1111 next cycle.
- PULSE, in=2, dwell=3, start pulse at edge k:
  - out=1011 and busy=1 on cycles k+1..k+3.
  - Cycle k+4: out=1111, done=1.
  - Repeat with dwell=0 -> exactly one low cycle, then done.
- SCAN, in=3, dwell=2:
  - Low line sequence is 3,3,0,0,1,1,2,2 (wrap 3->0 checked), busy=1 for 8 cycles, then one done pulse.
  - A start mid-scan is ignored.
- Abort and reset mid-operation:
  - SCAN with dwell=5, enable=1 raised on the 4th active cycle -> out=1111 and busy=0 next cycle, no done pulse.
  - Repeat, asserting reset mid-PULSE -> all outputs return to their reset values next cycle.
- Back-to-back operations:
  - Start asserted in the done cycle of a PULSE (in=1, dwell=1) -> new PULSE line low the next cycle.
  - mode=11 with start -> out=1111, busy=0.
